// File: rtl/hack_cpu_pkg.sv
// rtl/hack_cpu_pkg.sv - Hack ISA widths, instruction field positions, jump codes and decode helpers
package hack_cpu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 15;

  localparam int BIT_C   = 15;
  localparam int BIT_A   = 12;
  localparam int BIT_ZX  = 11;
  localparam int BIT_NX  = 10;
  localparam int BIT_ZY  = 9;
  localparam int BIT_NY  = 8;
  localparam int BIT_F   = 7;
  localparam int BIT_NO  = 6;
  localparam int BIT_DA  = 5;
  localparam int BIT_DD  = 4;
  localparam int BIT_DM  = 3;
  localparam int BIT_JLT = 2;
  localparam int BIT_JEQ = 1;
  localparam int BIT_JGT = 0;

  typedef enum logic [2:0] {
    JMP_NONE = 3'b000,
    JMP_JGT  = 3'b001,
    JMP_JEQ  = 3'b010,
    JMP_JGE  = 3'b011,
    JMP_JLT  = 3'b100,
    JMP_JNE  = 3'b101,
    JMP_JLE  = 3'b110,
    JMP_JMP  = 3'b111
  } jump_e;

  typedef struct packed {
    logic  is_c;
    logic  a;
    logic  zx;
    logic  nx;
    logic  zy;
    logic  ny;
    logic  f;
    logic  no;
    logic  da;
    logic  dd;
    logic  dm;
    jump_e jmp;
  } ctrl_t;

  // A-instructions yield an all-zero control word so the ALU sees zx..no = 0
  function automatic ctrl_t decode(input logic [DATA_W-1:0] ins);
    ctrl_t c;
    c = '0;
    c.jmp = JMP_NONE;
    if (ins[BIT_C]) begin
      c.is_c = 1'b1;
      c.a    = ins[BIT_A];
      c.zx   = ins[BIT_ZX];
      c.nx   = ins[BIT_NX];
      c.zy   = ins[BIT_ZY];
      c.ny   = ins[BIT_NY];
      c.f    = ins[BIT_F];
      c.no   = ins[BIT_NO];
      c.da   = ins[BIT_DA];
      c.dd   = ins[BIT_DD];
      c.dm   = ins[BIT_DM];
      c.jmp  = jump_e'(ins[BIT_JLT:BIT_JGT]);
    end
    return c;
  endfunction

  function automatic logic jump_taken(input jump_e j, input logic zr, input logic ng);
    logic t;
    case (j)
      JMP_NONE: t = 1'b0;
      JMP_JGT:  t = ~ng & ~zr;
      JMP_JEQ:  t = zr;
      JMP_JGE:  t = ~ng;
      JMP_JLT:  t = ng;
      JMP_JNE:  t = ~zr;
      JMP_JLE:  t = ng | zr;
      default:  t = 1'b1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/hack_cpu_alu.sv
// rtl/hack_cpu_alu.sv - combinational Hack ALU, 16-bit two's complement with zr/ng flags
module hack_cpu_alu
  import hack_cpu_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              zx,
  input  logic              nx,
  input  logic              zy,
  input  logic              ny,
  input  logic              f,
  input  logic              no,
  output logic [DATA_W-1:0] out,
  output logic              zr,
  output logic              ng
);

  logic [DATA_W-1:0] x1, x2, y1, y2, r;

  always_comb begin
    x1  = zx ? '0 : x;
    x2  = nx ? ~x1 : x1;
    y1  = zy ? '0 : y;
    y2  = ny ? ~y1 : y1;
    r   = f ? (x2 + y2) : (x2 & y2);
    out = no ? ~r : r;
    zr  = (out == '0);
    ng  = out[DATA_W-1];
  end

endmodule

// File: rtl/hack_cpu.sv
// rtl/hack_cpu.sv - single-cycle Hack CPU: decode, A/D/PC registers around the Hack ALU
module hack_cpu
  import hack_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] instruction,
  input  logic [DATA_W-1:0] inM,
  output logic [DATA_W-1:0] outM,
  output logic              writeM,
  output logic [ADDR_W-1:0] addressM,
  output logic [ADDR_W-1:0] pc
);

  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] d_reg;
  logic [ADDR_W-1:0] pc_reg;
  ctrl_t             ctrl;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] alu_out;
  logic              zr;
  logic              ng;
  logic              jump;

  assign ctrl  = decode(instruction);
  assign alu_y = ctrl.a ? inM : a_reg;

  hack_cpu_alu u_alu (
    .x   (d_reg),
    .y   (alu_y),
    .zx  (ctrl.zx),
    .nx  (ctrl.nx),
    .zy  (ctrl.zy),
    .ny  (ctrl.ny),
    .f   (ctrl.f),
    .no  (ctrl.no),
    .out (alu_out),
    .zr  (zr),
    .ng  (ng)
  );

  assign jump     = ctrl.is_c & jump_taken(ctrl.jmp, zr, ng);
  assign outM     = alu_out;
  assign writeM   = ctrl.is_c & ctrl.dm & en & rst_n;
  assign addressM = a_reg[ADDR_W-1:0];
  assign pc       = pc_reg;

  // The jump target is the pre-edge A, so a simultaneous A write never redirects the branch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg  <= '0;
      d_reg  <= '0;
      pc_reg <= '0;
    end else if (en) begin
      if (!ctrl.is_c)
        a_reg <= {1'b0, instruction[ADDR_W-1:0]};
      else if (ctrl.da)
        a_reg <= alu_out;
      if (ctrl.is_c && ctrl.dd)
        d_reg <= alu_out;
      pc_reg <= jump ? a_reg[ADDR_W-1:0] : pc_reg + 15'd1;
    end
  end

endmodule

// File: tb/tb_hack_cpu.sv
// tb/tb_hack_cpu.sv - self-checking bench for hack_cpu with directed scenarios and a scoreboarded random stream
module tb_hack_cpu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] instruction;
  logic [15:0] inM;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;
  logic [14:0] pc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] outm;
    logic        wm;
    logic [14:0] addr;
    logic [14:0] pcv;
  } exp_t;
  exp_t sb[$];

  hack_cpu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .instruction (instruction),
    .inM         (inM),
    .outM        (outM),
    .writeM      (writeM),
    .addressM    (addressM),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  // Present inputs just after a rising edge and return at the falling edge for sampling
  task automatic drive(input logic [15:0] ins, input logic [15:0] m, input logic e);
    instruction = ins;
    inM         = m;
    en          = e;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(16'h0000, 16'h0000, 1'b1);
    tick();
    rst_n = 1'b1;
  endtask

  // Reference ALU written from the Hack comp mnemonic table
  function automatic logic [15:0] model_comp(input logic [5:0] c, input logic [15:0] d, input logic [15:0] y);
    case (c)
      6'b101010: return 16'h0000;
      6'b111111: return 16'h0001;
      6'b111010: return 16'hFFFF;
      6'b001100: return d;
      6'b110000: return y;
      6'b001101: return ~d;
      6'b110001: return ~y;
      6'b001111: return -d;
      6'b110011: return -y;
      6'b011111: return d + 16'd1;
      6'b110111: return y + 16'd1;
      6'b001110: return d - 16'd1;
      6'b110010: return y - 16'd1;
      6'b000010: return d + y;
      6'b010011: return d - y;
      6'b000111: return y - d;
      6'b000000: return d & y;
      6'b010101: return d | y;
      default:   return 16'h0000;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive(16'hE308, 16'h1234, 1'b1);
    checks++; if (writeM !== 1'b0) begin errors++; $display("FAIL reset_writem got %b exp 0", writeM); end
    tick();
    drive(16'hE308, 16'h1234, 1'b0);
    checks++; if (pc !== 15'h0000) begin errors++; $display("FAIL reset_pc got %h exp 0000", pc); end
    checks++; if (addressM !== 15'h0000) begin errors++; $display("FAIL reset_addr got %h exp 0000", addressM); end
    rst_n = 1'b1;
    drive(16'hE300, 16'h0000, 1'b0);
    checks++; if (outM !== 16'h0000) begin errors++; $display("FAIL reset_d got %h exp 0000", outM); end
  endtask

  task automatic test_a_and_store();
    do_reset();
    drive(16'h0005, 16'h0000, 1'b1);
    checks++; if (writeM !== 1'b0) begin errors++; $display("FAIL ainst_writem got %b exp 0", writeM); end
    tick();
    drive(16'hEC10, 16'h0000, 1'b1);
    checks++; if (addressM !== 15'h0005) begin errors++; $display("FAIL ainst_a got %h exp 0005", addressM); end
    checks++; if (pc !== 15'h0001) begin errors++; $display("FAIL ainst_pc got %h exp 0001", pc); end
    tick();
    drive(16'hE308, 16'h0000, 1'b1);
    checks++; if (outM !== 16'h0005) begin errors++; $display("FAIL store_outm got %h exp 0005", outM); end
    checks++; if (addressM !== 15'h0005) begin errors++; $display("FAIL store_addr got %h exp 0005", addressM); end
    checks++; if (writeM !== 1'b1) begin errors++; $display("FAIL store_writem got %b exp 1", writeM); end
    tick();
    drive(16'hE300, 16'h0000, 1'b1);
    checks++; if (writeM !== 1'b0) begin errors++; $display("FAIL store_once got %b exp 0", writeM); end
    checks++; if (outM !== 16'h0005) begin errors++; $display("FAIL store_d got %h exp 0005", outM); end
    tick();
  endtask

  task automatic test_jumps();
    do_reset();
    drive(16'h0005, 16'h0000, 1'b1); tick();
    drive(16'hEC10, 16'h0000, 1'b1); tick();
    drive(16'h0010, 16'h0000, 1'b1); tick();
    drive(16'hE301, 16'h0000, 1'b1); tick();
    checks++; if (pc !== 15'h0010) begin errors++; $display("FAIL jgt_taken got %h exp 0010", pc); end
    drive(16'hEA90, 16'h0000, 1'b1); tick();
    drive(16'hE301, 16'h0000, 1'b1); tick();
    checks++; if (pc !== 15'h0012) begin errors++; $display("FAIL jgt_not_taken got %h exp 0012", pc); end
    drive(16'hE302, 16'h0000, 1'b1); tick();
    checks++; if (pc !== 15'h0010) begin errors++; $display("FAIL jeq_taken got %h exp 0010", pc); end
    // dA with jump: branch goes to old A (0x10), A takes result (0)
    drive(16'hEAA7, 16'h0000, 1'b1); tick();
    checks++; if (pc !== 15'h0010) begin errors++; $display("FAIL da_jump_pc got %h exp 0010", pc); end
    checks++; if (addressM !== 15'h0000) begin errors++; $display("FAIL da_jump_a got %h exp 0000", addressM); end
  endtask

  task automatic test_enable();
    do_reset();
    drive(16'h0007, 16'h0000, 1'b1); tick();
    drive(16'hEC10, 16'h0000, 1'b1); tick();
    drive(16'h0020, 16'h0000, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(16'hEA87, 16'h0000, 1'b0);
      checks++; if (writeM !== 1'b0) begin errors++; $display("FAIL hold_writem[%0d] got %b exp 0", i, writeM); end
      checks++; if (pc !== 15'h0003) begin errors++; $display("FAIL hold_pc[%0d] got %h exp 0003", i, pc); end
      checks++; if (addressM !== 15'h0020) begin errors++; $display("FAIL hold_a[%0d] got %h exp 0020", i, addressM); end
      tick();
    end
    drive(16'hE318, 16'h0000, 1'b0);
    checks++; if (writeM !== 1'b0) begin errors++; $display("FAIL hold_dm got %b exp 0", writeM); end
    tick();
    drive(16'hEA87, 16'h0000, 1'b1); tick();
    checks++; if (pc !== 15'h0020) begin errors++; $display("FAIL resume_pc got %h exp 0020", pc); end
    drive(16'hE300, 16'h0000, 1'b1);
    checks++; if (outM !== 16'h0007) begin errors++; $display("FAIL hold_d got %h exp 0007", outM); end
    tick();
  endtask

  task automatic test_wrap_and_neg();
    do_reset();
    drive(16'h7FFF, 16'h0000, 1'b1); tick();
    drive(16'hEA87, 16'h0000, 1'b1); tick();
    checks++; if (pc !== 15'h7FFF) begin errors++; $display("FAIL reach_top got %h exp 7fff", pc); end
    drive(16'hEA90, 16'h0000, 1'b1); tick();
    checks++; if (pc !== 15'h0000) begin errors++; $display("FAIL pc_wrap got %h exp 0000", pc); end
    drive(16'hE390, 16'h0000, 1'b1);
    checks++; if (outM !== 16'hFFFF) begin errors++; $display("FAIL dec_result got %h exp ffff", outM); end
    tick();
    drive(16'hE304, 16'h0000, 1'b1);
    checks++; if (outM !== 16'hFFFF) begin errors++; $display("FAIL dec_d got %h exp ffff", outM); end
    tick();
    checks++; if (pc !== 15'h7FFF) begin errors++; $display("FAIL jlt_ng got %h exp 7fff", pc); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(16'h0005, 16'h0000, 1'b1); tick();
    drive(16'hEC10, 16'h0000, 1'b1); tick();
    drive(16'h0009, 16'h0000, 1'b1); tick();
    rst_n = 1'b0;
    drive(16'hE308, 16'h0000, 1'b1);
    checks++; if (writeM !== 1'b0) begin errors++; $display("FAIL midrst_writem got %b exp 0", writeM); end
    tick();
    rst_n = 1'b1;
    drive(16'hE300, 16'h0000, 1'b1);
    checks++; if (pc !== 15'h0000) begin errors++; $display("FAIL midrst_pc got %h exp 0000", pc); end
    checks++; if (addressM !== 15'h0000) begin errors++; $display("FAIL midrst_a got %h exp 0000", addressM); end
    checks++; if (outM !== 16'h0000) begin errors++; $display("FAIL midrst_d got %h exp 0000", outM); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0]  comps [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
                                6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
                                6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};
    logic [15:0] m_a, m_d, ins, m, y, r;
    logic [14:0] m_pc;
    logic        e, is_c, zr, ng, jmp;
    exp_t        x, got;
    do_reset();
    m_a = 16'h0; m_d = 16'h0; m_pc = 15'h0;
    for (int i = 0; i < 400; i++) begin
      m = 16'($urandom);
      e = ($urandom % 8) != 0;
      if ($urandom % 4 == 0)
        ins = {1'b0, 15'($urandom)};
      else
        ins = {3'b111, 1'($urandom), comps[$urandom % 18], 3'($urandom), 3'($urandom)};
      is_c = ins[15];
      y = (is_c && ins[12]) ? m : m_a;
      r = is_c ? model_comp(ins[11:6], m_d, y) : (m_d & m_a);
      ng = r[15];
      zr = (r == 16'h0);
      jmp = is_c && ((ins[2] && ng) || (ins[1] && zr) || (ins[0] && !ng && !zr));
      x.outm = r; x.wm = is_c & ins[3] & e; x.addr = m_a[14:0]; x.pcv = m_pc;
      sb.push_back(x);
      drive(ins, m, e);
      if (sb.size() == 0) begin
        errors++; $display("FAIL sb_empty at %0d", i);
      end else begin
        x = sb.pop_front();
        got.outm = outM; got.wm = writeM; got.addr = addressM; got.pcv = pc;
        checks++; if (got.outm !== x.outm) begin errors++; $display("FAIL rnd_outm[%0d] ins %h got %h exp %h", i, ins, got.outm, x.outm); end
        checks++; if (got.wm !== x.wm) begin errors++; $display("FAIL rnd_writem[%0d] ins %h got %b exp %b", i, ins, got.wm, x.wm); end
        checks++; if (got.addr !== x.addr) begin errors++; $display("FAIL rnd_addr[%0d] got %h exp %h", i, got.addr, x.addr); end
        checks++; if (got.pcv !== x.pcv) begin errors++; $display("FAIL rnd_pc[%0d] got %h exp %h", i, got.pcv, x.pcv); end
      end
      tick();
      if (e) begin
        m_pc = jmp ? m_a[14:0] : m_pc + 15'd1;
        if (!is_c) m_a = {1'b0, ins[14:0]};
        else if (ins[5]) m_a = r;
        if (is_c && ins[4]) m_d = r;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    instruction = 16'h0000;
    inM = 16'h0000;
    @(posedge clk);
    #1;
    test_reset();
    test_a_and_store();
    test_jumps();
    test_enable();
    test_wrap_and_neg();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
